regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Architectural integer register file at the consuming end of the write-back interface. Accepts the wb_wd/wb_wreg/wb_wdata write registered in the MEM/WB stage.
- Serves two operand reads to the ID stage.
- Per-register scoreboard counts in-flight writes issued from ID but not yet written back. Raises a stall request to ctrl when an operand is not yet available.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 hardwired to zero.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- CNT_W, 2, width of each per-register in-flight counter; max 3 outstanding writes (EX, MEM, WB).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset: rst==0 at a rising edge resets the block.
- rdy  in  1  global ready; 0 freezes all state.
- wb_wd  in  ADDR_W  write-back destination register.
- wb_wreg  in  1  write-back enable.
- wb_wdata  in  DATA_W  write-back data.
- re1  in  1  read port 1 enable.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- re2  in  1  read port 2 enable.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- issue_valid  in  1  ID instruction leaving ID this cycle.
- issue_wd  in  ADDR_W  its destination register.
- issue_wreg  in  1  its write enable.
- stallreq_reg  out  1  operand-hazard stall request to ctrl (combinational).

Behaviour:
- Reset (rst==0 at edge):
  - All registers cleared to 0; all counters cleared to 0.
  - While rst==0, rdata1/rdata2/stallreq_reg are forced to 0.
- rdy==0, rst==1:
  - No array write, no counter change.
  - Read paths and stall output remain live.
- Write: at edge, if wb_wreg && wb_wd!=0, reg[wb_wd] <= wb_wdata. Writes to x0 are dropped.
- Read port n:
  - Output 0 if !ren or raddrn==0.
  - Otherwise reg[raddrn], or wb_wdata under the bypass rule (Optional Feature).
- Operand n is busy when ren && raddrn!=0 && cnt[raddrn]!=0, except when it is bypass-satisfied (Optional Feature).
- stallreq_reg = busy1 | busy2.
- Issue accept: issue_ok = issue_valid && issue_wreg && issue_wd!=0 && !stallreq_reg. A stalled instruction is never counted, including one that reads its own rd.
- Counter update at edge, per register r, with inc = (issue_ok && issue_wd==r) and dec = (wb_wreg && wb_wd==r && r!=0):
  - inc only: +1.
  - dec only: -1.
  - both: unchanged.
  - neither: unchanged.
- Counter boundaries:
  - Increment at max value (2^CNT_W-1) or decrement at 0 is a protocol violation.
  - The counter saturates (holds its value) and a simulation-only $display error fires.
- Latency:
  - A write is visible in the array on the cycle after the edge that commits it.
  - Counter changes are visible on the cycle after the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rdatan = wb_wdata when wb_wreg && wb_wd==raddrn && raddrn!=0.
  - Operand is not busy when cnt[raddrn]==1 and the same-cycle write-back targets raddrn.
- Undefined:
  - No forwarding; rdatan always comes from the array.
  - Busy whenever cnt!=0, so there is a one-cycle extra stall after write-back.

Test Plan:
- Reset: hold rst=0 two cycles with wb_wreg=1, wb_wd=3 -> reg3 reads 0 after release; stallreq_reg=0; all counters 0.
- x0 protection: write wb_wd=0, wb_wdata=0xDEADBEEF; then read raddr1=0 -> rdata1=0; issue to rd 0 -> no stall on a later read of 0.
- Hazard: issue rd=5; next cycle read raddr1=5 -> stallreq_reg=1 until write-back (wb_wd=5, wb_wdata=0x12345678).
  - With bypass: stall drops in the write-back cycle and rdata1=0x12345678.
  - Without bypass: stall drops one cycle later with the same data.
- Double in-flight: issue rd=7 twice on consecutive cycles (cnt=2); first write-back (wb_wd=7) -> still stalled (cnt=1) even with bypass; second write-back -> released.
- Simultaneous: issue rd=9 in the same cycle as write-back to 9 with cnt[9]=1 -> cnt[9] stays 1 and a later read of 9 stalls.
- rdy freeze: rdy=0 with wb_wreg=1, wb_wd=4, wb_wdata=0xA5A5A5A5 and issue_valid=1 to rd=6 -> reg4 unchanged, cnt[6] stays 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register in-flight write scoreboard.
// Define REGFILE_BYPASS_EN to forward the same-cycle write-back to the reads.
module regfile_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_wd,
  input  logic              issue_wreg,
  output logic              stallreq_reg
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [CNT_W-1:0]  cnt  [REG_NUM];

  logic               hit1, hit2;
  logic               busy1, busy2;
  logic               issue_ok;
  logic [REG_NUM-1:0] inc, dec;

`ifdef REGFILE_BYPASS_EN
  assign hit1 = wb_wreg && (wb_wd == raddr1) && (raddr1 != '0);
  assign hit2 = wb_wreg && (wb_wd == raddr2) && (raddr2 != '0);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    rdata1 = '0;
    if (rst && re1 && raddr1 != '0)
      rdata1 = hit1 ? wb_wdata : regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (rst && re2 && raddr2 != '0)
      rdata2 = hit2 ? wb_wdata : regs[raddr2];
  end

  // A lone pending write completing this cycle is satisfied by the bypass
  assign busy1 = re1 && (raddr1 != '0) && (cnt[raddr1] != '0)
               && !(hit1 && cnt[raddr1] == CNT_ONE);
  assign busy2 = re2 && (raddr2 != '0) && (cnt[raddr2] != '0)
               && !(hit2 && cnt[raddr2] == CNT_ONE);

  assign stallreq_reg = rst && (busy1 || busy2);

  assign issue_ok = issue_valid && issue_wreg
                  && (issue_wd != '0) && !stallreq_reg;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      inc[r] = issue_ok && (issue_wd == ADDR_W'(r));
      dec[r] = wb_wreg && (wb_wd == ADDR_W'(r)) && (r != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else if (rdy) begin
      if (wb_wreg && wb_wd != '0)
        regs[wb_wd] <= wb_wdata;
      // Out-of-range updates saturate instead of wrapping
      for (int r = 0; r < REG_NUM; r++) begin
        if (inc[r] && !dec[r]) begin
          if (cnt[r] != CNT_MAX)
            cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec[r] && !inc[r]) begin
          if (cnt[r] != '0)
            cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      for (int r = 0; r < REG_NUM; r++) begin
        assert (!(inc[r] && !dec[r] && cnt[r] == CNT_MAX))
          else $error("regfile_scoreboard: counter overflow on x%0d", r);
        assert (!(dec[r] && !inc[r] && cnt[r] == '0))
          else $error("regfile_scoreboard: counter underflow on x%0d", r);
      end
    end
  end

endmodule
